mux_rr_arbiter: RTL and testbench

- Two-source round-robin arbiter that sits directly upstream of the team's 2-bit 2:1 mux.
- Accepts 2-bit words from sources A and B over valid/ready handshakes and drives the mux select.
- Registers the selected word into a one-entry output stage with its own valid/ready handshake.
- Keeps saturating per-source grant counters for debug.

---
 rtl/mux_rr_arbiter.sv | 90 +++++++++
 tb/tb_mux_rr_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Two-source round-robin arbiter feeding a 2:1 mux select, with a one-entry
// registered output stage and saturating per-source grant counters.
module mux_rr_arbiter #(
   parameter int unsigned DATA_W = 2,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] a_data,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [DATA_W-1:0] b_data,
   input  logic              b_valid,
   output logic              b_ready,
   output logic              sel,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_src,
   output logic [CNT_W-1:0]  grant_cnt_a,
   output logic [CNT_W-1:0]  grant_cnt_b
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t state;
   logic   last;      // 1 = B won the most recent accept
   logic   load_en;
   logic   grant_a;
   logic   grant_b;
   logic   accept;

   // Output stage can take a word when empty or draining this cycle
   assign load_en   = (state == EMPTY) || out_ready;
   assign out_valid = (state == FULL);

   // Round-robin grant: on contention the source that did not win last goes
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (load_en) begin
         if (a_valid && b_valid) begin
            grant_a = last;
            grant_b = !last;
         end else begin
            grant_a = a_valid;
            grant_b = b_valid;
         end
      end
   end

   assign accept  = grant_a || grant_b;
   assign a_ready = grant_a;
   assign b_ready = grant_b;
   // With no grant the select parks on the last winner
   assign sel     = grant_b ? 1'b1 : (grant_a ? 1'b0 : last);

   // Output-stage FSM, data/source capture, last winner and grant counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= EMPTY;
         out_data    <= '0;
         out_src     <= 1'b0;
         last        <= 1'b1;
         grant_cnt_a <= '0;
         grant_cnt_b <= '0;
      end else begin
         case (state)
            EMPTY: if (accept) state <= FULL;
            FULL:  if (out_ready && !accept) state <= EMPTY;
            default: state <= EMPTY;
         endcase
         if (accept) begin
            out_data <= sel ? b_data : a_data;
            out_src  <= sel;
            last     <= sel;
         end
         if (grant_a && (grant_cnt_a != CNT_MAX))
            grant_cnt_a <= grant_cnt_a + CNT_W'(1);
         if (grant_b && (grant_cnt_b != CNT_MAX))
            grant_cnt_b <= grant_cnt_b + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios with literal expectations plus
// a randomized run, all checked every cycle against a behavioural model.
module tb_mux_rr_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] a_data, b_data;
   logic       a_valid, b_valid, out_ready;

   logic       a_ready, b_ready, sel, out_valid, out_src;
   logic [1:0] out_data;
   logic [7:0] grant_cnt_a, grant_cnt_b;

   logic       a_ready2, b_ready2, sel2, out_valid2, out_src2;
   logic [1:0] out_data2;
   logic [1:0] grant_cnt_a2, grant_cnt_b2;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mux_rr_arbiter #(.DATA_W(2), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
      .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
      .sel(sel), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_src(out_src),
      .grant_cnt_a(grant_cnt_a), .grant_cnt_b(grant_cnt_b)
   );

   // Narrow-counter instance sharing the same stimulus, for saturation
   mux_rr_arbiter #(.DATA_W(2), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset),
      .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready2),
      .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready2),
      .sel(sel2), .out_data(out_data2), .out_valid(out_valid2),
      .out_ready(out_ready), .out_src(out_src2),
      .grant_cnt_a(grant_cnt_a2), .grant_cnt_b(grant_cnt_b2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_valid, m_data, m_src, m_last;
   int m_cnt[2];    // 8-bit counters, index 0 = A, 1 = B
   int m_cnt2[2];   // 2-bit counters

   // Which source wins this cycle: -1 none, 0 A, 1 B
   function automatic int pick(input int room, input int av, input int bv, input int lastw);
      if (!room) return -1;
      if (av && bv) return (lastw == 0) ? 1 : 0;
      if (av) return 0;
      if (bv) return 1;
      return -1;
   endfunction

   function automatic int room_now();
      return (!m_valid || out_ready) ? 1 : 0;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_valid = 0; m_data = 0; m_src = 0; m_last = 1;
         m_cnt[0] = 0; m_cnt[1] = 0; m_cnt2[0] = 0; m_cnt2[1] = 0;
      end else begin
         int g;
         g = pick(room_now(), int'(a_valid), int'(b_valid), m_last);
         if (g < 0) begin
            if (m_valid && out_ready) m_valid = 0;
         end else begin
            m_data  = (g == 1) ? int'(b_data) : int'(a_data);
            m_src   = g;
            m_last  = g;
            m_valid = 1;
            m_cnt[g]  = (m_cnt[g]  < 255) ? m_cnt[g]  + 1 : 255;
            m_cnt2[g] = (m_cnt2[g] < 3)   ? m_cnt2[g] + 1 : 3;
         end
      end
   end

   // Every-cycle comparison against the model, half a period from the edge
   always @(negedge clk) begin
      if (!reset) begin
         int g;
         g = pick(room_now(), int'(a_valid), int'(b_valid), m_last);
         check("a_ready",   32'(a_ready),   32'(g == 0));
         check("b_ready",   32'(b_ready),   32'(g == 1));
         check("sel",       32'(sel),       32'((g < 0) ? m_last : g));
         check("out_valid", 32'(out_valid), 32'(m_valid));
         check("out_data",  32'(out_data),  32'(m_data));
         check("out_src",   32'(out_src),   32'(m_src));
         check("cnt_a",     32'(grant_cnt_a),  32'(m_cnt[0]));
         check("cnt_b",     32'(grant_cnt_b),  32'(m_cnt[1]));
         check("cnt2_a",    32'(grant_cnt_a2), 32'(m_cnt2[0]));
         check("cnt2_b",    32'(grant_cnt_b2), 32'(m_cnt2[1]));
         check("out_data2", 32'(out_data2), 32'(m_data));
      end
   end

   // ---------------- directed + random stimulus ----------------
   task automatic idle_inputs();
      a_valid = 1'b0; b_valid = 1'b0; a_data = 2'b00; b_data = 2'b00;
   endtask

   // Reset pulse asserted and released between clock edges
   task automatic do_reset();
      @(posedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #3;
      reset = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      logic [1:0] exp_d [4];
      logic       exp_s [4];
      logic [1:0] exp_c2 [6];

      exp_d = '{2'b01, 2'b10, 2'b01, 2'b10};
      exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
      exp_c2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

      reset = 1'b1;
      out_ready = 1'b0;
      idle_inputs();

      // Reset state, then alternating contention A,B,A,B
      a_valid = 1'b1; b_valid = 1'b1; a_data = 2'b01; b_data = 2'b10; out_ready = 1'b1;
      #8;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_out_src",   32'(out_src),   32'd0);
      check("rst_cnt_a",     32'(grant_cnt_a), 32'd0);
      check("rst_cnt_b",     32'(grant_cnt_b), 32'd0);
      #4 reset = 1'b0;
      #1;
      check("first_contention_a_ready", 32'(a_ready), 32'd1);
      check("first_contention_sel",     32'(sel),     32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("alt_out_data", 32'(out_data), 32'(exp_d[i]));
         check("alt_out_src",  32'(out_src),  32'(exp_s[i]));
         if (i == 3) idle_inputs();
      end
      check("alt_cnt_a", 32'(grant_cnt_a), 32'd2);
      check("alt_cnt_b", 32'(grant_cnt_b), 32'd2);

      // B-only stream
      do_reset();
      b_valid = 1'b1; b_data = 2'b11;
      #1;
      check("bonly_b_ready", 32'(b_ready), 32'd1);
      check("bonly_sel",     32'(sel),     32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bonly_out_data", 32'(out_data), 32'd3);
         check("bonly_out_src",  32'(out_src),  32'd1);
      end
      idle_inputs();
      check("bonly_cnt_b", 32'(grant_cnt_b), 32'd3);
      check("bonly_cnt_a", 32'(grant_cnt_a), 32'd0);

      // Backpressure holds the stage, then B wins on release
      do_reset();
      a_valid = 1'b1; a_data = 2'b10;
      tick();
      check("bp_first", 32'(out_data), 32'd2);
      out_ready = 1'b0; b_valid = 1'b1; b_data = 2'b01; a_data = 2'b00;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("bp_hold_data",  32'(out_data),  32'd2);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_a_ready",    32'(a_ready),   32'd0);
         check("bp_b_ready",    32'(b_ready),   32'd0);
      end
      out_ready = 1'b1;
      #1 check("bp_release_b_ready", 32'(b_ready), 32'd1);
      tick();
      check("bp_release_data", 32'(out_data), 32'd1);
      check("bp_release_src",  32'(out_src),  32'd1);
      idle_inputs();

      // Single A word: valid for exactly one cycle, then B wins contention
      do_reset();
      a_valid = 1'b1; a_data = 2'b01;
      tick();
      idle_inputs();
      check("single_valid_hi", 32'(out_valid), 32'd1);
      tick();
      check("single_valid_lo", 32'(out_valid), 32'd0);
      a_valid = 1'b1; b_valid = 1'b1;
      #1;
      check("single_next_b_ready", 32'(b_ready), 32'd1);
      check("single_next_sel",     32'(sel),     32'd1);
      idle_inputs();

      // 2-bit counter saturation on an A-only stream
      do_reset();
      a_valid = 1'b1; a_data = 2'b11;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("sat_cnt2_a", 32'(grant_cnt_a2), 32'(exp_c2[i]));
      end
      idle_inputs();

      // Asynchronous reset while a word is held
      do_reset();
      out_ready = 1'b0; a_valid = 1'b1; a_data = 2'b11;
      tick();
      idle_inputs();
      check("arst_pre_valid", 32'(out_valid), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("arst_valid", 32'(out_valid),   32'd0);
      check("arst_data",  32'(out_data),    32'd0);
      check("arst_cnt_a", 32'(grant_cnt_a), 32'd0);
      check("arst_cnt_b", 32'(grant_cnt_b), 32'd0);
      #2 reset = 1'b0;
      out_ready = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
      #1;
      check("arst_after_a_ready", 32'(a_ready), 32'd1);
      idle_inputs();

      // Randomized traffic with occasional mid-run resets
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         tick();
         a_valid   = ($urandom_range(0, 99) < 60);
         b_valid   = ($urandom_range(0, 99) < 60);
         a_data    = 2'($urandom);
         b_data    = 2'($urandom);
         out_ready = ($urandom_range(0, 99) < 65);
         if ($urandom_range(0, 499) == 0) begin
            #2 reset = 1'b1;
            #3 reset = 1'b0;
         end
      end
      idle_inputs();
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
